// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the E-stage multiply/divide unit:
//   - MDU op encoding (4-bit)
//   - sequencer state encoding (IDLE/BUSY)
//   - default multiply/divide latencies
//   - divide-by-zero quotient constant
//   - is_long_op(): which ops start the multi-cycle sequencer
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (ops 9/10).
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Quotient returned for any divide by zero (signed or unsigned).
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Ops that occupy the sequencer for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) ||
        (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Combinational datapath for the MDU. From the latched operands/op and the
// current HI:LO it produces the HI:LO value to commit when the sequencer
// finishes.
// Ports:
//   i_op         latched MDU op
//   i_a, i_b     latched rs / rt operands
//   i_hi, i_lo   current HI/LO (accumulate source)
//   o_hi, o_lo   result to commit
// Optional feature macro: MDU_MADD_EN builds the 64-bit accumulate adder.
// -----------------------------------------------------------------------------
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  // Signed product: lower 64 bits of the product of sign-extended operands.
  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_a_sx   = {{32{i_a[31]}}, i_a};
  assign w_b_sx   = {{32{i_b[31]}}, i_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // One unsigned divider serves both DIV and DIVU. For DIV the operands are
  // converted to magnitudes and the signs restored afterwards, which gives
  // truncation toward zero and a remainder carrying the dividend's sign.
  // 0x8000_0000 / -1 falls out naturally: magnitude 0x8000_0000 / 1, then
  // negated back to 0x8000_0000 with remainder 0.
  logic        w_div_s;
  logic        w_b_nz;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_div_s = (i_op == OP_DIV);
  assign w_b_nz  = (i_b != 32'd0);
  assign w_a_mag = (w_div_s && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_b_mag = (w_div_s && i_b[31]) ? (~i_b + 32'd1) : i_b;
  // Keep the divider away from a zero divisor; the zero case is overridden.
  assign w_b_div = w_b_nz ? w_b_mag : 32'd1;
  assign w_q_mag = w_a_mag / w_b_div;
  assign w_r_mag = w_a_mag % w_b_div;
  assign w_quot  = (w_div_s && (i_a[31] ^ i_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = (w_div_s && i_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc_s;
  logic [63:0] w_acc_u;
  assign w_acc_s = {i_hi, i_lo} + w_prod_s;
  assign w_acc_u = {i_hi, i_lo} + w_prod_u;
`endif

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    case (i_op)
      OP_MULT:  {o_hi, o_lo} = w_prod_s;
      OP_MULTU: {o_hi, o_lo} = w_prod_u;
      OP_DIV, OP_DIVU: begin
        if (w_b_nz) begin
          o_hi = w_rem;
          o_lo = w_quot;
        end else begin
          o_hi = i_a;
          o_lo = DIV0_QUOT;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {o_hi, o_lo} = w_acc_s;
      OP_MADDU: {o_hi, o_lo} = w_acc_u;
`endif
      default: begin
        o_hi = i_hi;
        o_lo = i_lo;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu
// E-stage multiply/divide unit. Owns HI/LO, runs a two-state multi-cycle
// sequencer and raises busy so the hazard unit can stall later HI/LO users.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   req          exception/interrupt flush of this cycle's E-stage instruction
//   start        E-stage instruction is a valid MDU instruction
//   op[3:0]      MDU op (see mdu_pkg)
//   A, B         forwarded rs / rt values
//   busy         multi-cycle operation in progress
//   mdu_out      MFHI/MFLO read data (combinational on op)
//   o_dbg_state  sequencer state, for observation only
// Handshake: an instruction is taken when start && !req && !busy at a rising
// edge; otherwise nothing changes. Once BUSY, req does not abort the op.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (ops 9/10); without
// it those ops are no-ops.
// -----------------------------------------------------------------------------
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] mdu_out,
  output mdu_state_e  o_dbg_state
);

  // Counter only ever holds latency-1, so $clog2(max latency) bits suffice.
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  mdu_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_accept;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  assign w_accept = start && !req && (r_state == ST_IDLE);

  mdu_arith u_arith (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_long_op(op)) begin
              r_state <= ST_BUSY;
              r_op    <= op;
              r_a     <= A;
              r_b     <= B;
              r_cnt   <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
            end else if (op == OP_MTHI) begin
              r_hi <= A;
            end else if (op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        ST_BUSY: begin
          // Commit on the edge where the counter has reached zero; HI:LO read
          // by the accumulate path is the value held at that moment.
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_BUSY);
  assign o_dbg_state = r_state;

  always_comb begin
    case (op)
      OP_MFHI: mdu_out = r_hi;
      OP_MFLO: mdu_out = r_lo;
      default: mdu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu
// Directed vectors for e_mdu. Drivers push expected HI/LO read data into a
// queue; a monitor pops and compares whenever a read is presented.
// Expectations for ops 9/10 follow MDU_MADD_EN.
// -----------------------------------------------------------------------------
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op    = OP_NONE;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        busy;
  logic [31:0] mdu_out;
  mdu_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  logic        rd_chk = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] m_exp;
  string       m_name;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .mdu_out     (mdu_out),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares mdu_out against the scoreboard when a read is presented.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read with empty queue, expected none");
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        check(m_name, mdu_out, m_exp);
      end
    end
  end

  task automatic rd(input logic [3:0] o, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; op = o;
    exp_q.push_back(e); name_q.push_back(nm); rd_chk = 1'b1;
    @(negedge clk); #1;
    rd_chk = 1'b0; op = OP_NONE;
  endtask

  task automatic rd_hilo(input logic [31:0] hi, input logic [31:0] lo, input string nm);
    rd(OP_MFHI, hi, {nm, "_hi"});
    rd(OP_MFLO, lo, {nm, "_lo"});
  endtask

  // Issue a long op; req_s is req in the issue cycle, req_b is req held
  // through the busy period. Counts busy cycles (bounded) and checks them.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic req_s, input logic req_b, input int exp_n, input string nm);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b; req = req_s;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE; req = req_b;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    check({nm, "_busy"}, 32'(n), 32'(exp_n));
  endtask

  // MTHI/MTLO followed by a read in the very next cycle.
  task automatic mt_rd(input logic [3:0] o, input logic [31:0] a, input logic r,
                       input logic [3:0] rd_o, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; req = r;
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0;
    check({nm, "_busy"}, 32'(busy), 32'd0);
    op = rd_o;
    exp_q.push_back(e); name_q.push_back(nm); rd_chk = 1'b1;
    @(negedge clk); #1;
    rd_chk = 1'b0; op = OP_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_out", mdu_out, 32'd0);
    reset = 1'b1;
    rd_hilo(32'd0, 32'd0, "rst");

    // Multiply / divide vectors
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 5, "mult_neg");
    rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, 10, "divu_z");
    rd_hilo(32'd7, 32'hFFFF_FFFF, "divu_z");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 10, "div_m7_2");
    rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 10, "div_7_m2");
    rd_hilo(32'd1, 32'hFFFF_FFFD, "div_7_m2");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, "div_ovf");
    rd_hilo(32'd0, 32'h8000_0000, "div_ovf");
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 10, "div_z");
    rd_hilo(32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_z");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5, "multu_max");
    rd_hilo(32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0, 10, "divu_10");
    rd_hilo(32'd5, 32'h1999_9999, "divu_10");

    // Moves to HI/LO
    mt_rd(OP_MTLO, 32'h1234_5678, 1'b0, OP_MFLO, 32'h1234_5678, "mtlo");
    mt_rd(OP_MTHI, 32'hAAAA_0000, 1'b0, OP_MFHI, 32'hAAAA_0000, "mthi");
    mt_rd(OP_MTHI, 32'h5555_5555, 1'b1, OP_MFHI, 32'hAAAA_0000, "mthi_req");
    rd(OP_NONE, 32'd0, "out_none");
    rd(OP_MTHI, 32'd0, "out_mthi");

    // req during busy does not abort; start+req is not accepted
    run_op(OP_MULT, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b1, 5, "mult_req");
    rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FED4, "mult_req");
    run_op(OP_MULT, 32'd2, 32'd3, 1'b1, 1'b0, 0, "start_req");
    rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FED4, "start_req");

    // Reset in busy cycle 3 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    op = OP_MFHI;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", mdu_out, 32'd0);
    op = OP_MFLO;
    #1;
    check("arst_lo", mdu_out, 32'd0);
    op = OP_NONE;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("arst_nobusy", 32'(n), 32'd0);
    rd_hilo(32'd0, 32'd0, "arst_after");

    // Accumulate ops
    mt_rd(OP_MTHI, 32'd0, 1'b0, OP_MFHI, 32'd0, "acc_sethi");
    mt_rd(OP_MTLO, 32'd5, 1'b0, OP_MFLO, 32'd5, "acc_setlo");
`ifdef MDU_MADD_EN
    run_op(OP_MADDU, 32'd2, 32'd3, 1'b0, 1'b0, 5, "maddu");
    rd_hilo(32'd0, 32'd11, "maddu");
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 5, "madd");
    rd_hilo(32'd0, 32'd8, "madd");
`else
    run_op(OP_MADDU, 32'd2, 32'd3, 1'b0, 1'b0, 0, "maddu");
    rd_hilo(32'd0, 32'd5, "maddu");
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 0, "madd");
    rd_hilo(32'd0, 32'd5, "madd");
`endif
    mt_rd(OP_MTHI, 32'hFFFF_FFFF, 1'b0, OP_MFHI, 32'hFFFF_FFFF, "wrap_sethi");
    mt_rd(OP_MTLO, 32'hFFFF_FFFF, 1'b0, OP_MFLO, 32'hFFFF_FFFF, "wrap_setlo");
`ifdef MDU_MADD_EN
    run_op(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, 5, "maddu_wrap");
    rd_hilo(32'd0, 32'd0, "maddu_wrap");
`else
    run_op(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, 0, "maddu_wrap");
    rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu_wrap");
`endif

    // Back-to-back: second op issued in the first idle cycle
    run_op(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0, 5, "b2b_first");
    start = 1'b1; A = 32'd5; B = 32'd6;
`ifdef MDU_MADD_EN
    op = OP_MADDU;
`else
    op = OP_MULTU;
`endif
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_busy", 32'(n), 32'd5);
`ifdef MDU_MADD_EN
    rd_hilo(32'd0, 32'd42, "b2b");
`else
    rd_hilo(32'd0, 32'd30, "b2b");
`endif

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage. It sits directly upstream of the E/M pipeline register and drives the `E_MDU_out` value that register captures. It owns the HI and LO registers and runs a multi-cycle multiply/divide sequencer. It raises `busy` so the hazard unit can stall later HI/LO users.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU/MADD/MADDU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  exception/interrupt flush; cancels the E-stage instruction presented this cycle.
- `start`  in  1  E-stage instruction is a valid MDU instruction.
- `op`  in  4  MDU operation, encoded per the Operation section.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `busy`  out  1  multi-cycle operation in progress.
- `mdu_out`  out  32  MFHI/MFLO read data.

## Operation
- Op encoding:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU.
  - 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - 9 MADD, 10 MADDU.
  - 11–15 are no-ops.
- Accept condition is `start && !req && !busy`. Anything else leaves state unchanged.
- FSM has two states:
  - IDLE → BUSY on accepted MULT/MULTU/DIV/DIVU/MADD/MADDU. On entry, latch `A`, `B` and `op`, and load the down-counter with the latency − 1.
  - BUSY decrements the counter each cycle.
  - BUSY → IDLE on the edge where the counter is 0; HI/LO are written on that same edge.
- Arithmetic (64-bit product, written as HI:LO):
  - MULT: signed product.
  - MULTU: unsigned product.
  - MADD/MADDU: HI:LO + product (signed/unsigned), modulo 2^64. The HI:LO value used is the one sampled at completion.
- DIV/DIVU:
  - Normal case: LO = quotient, HI = remainder.
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (either op): LO = 32'hFFFF_FFFF, HI = A.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- MTHI/MTLO: when accepted, write `A` into HI/LO at the clock edge; no busy.
- MFHI/MFLO: `mdu_out` is combinational, HI for op 5 and LO for op 6, otherwise 0. It is not gated by `req` or `busy`.
- While BUSY, `req` does not abort the running operation; it completes and commits.
- A `start` while busy is ignored. The hazard unit guarantees it never occurs.

## Timing
- Reset (asynchronous, `reset` = 0): HI = 0, LO = 0, counter = 0, state IDLE, `busy` = 0, `mdu_out` = 0.
- Reset asserted mid-operation discards the operation with no HI/LO write.
- Accept at edge t:
  - `busy` = 1 for exactly N cycles (edges t+1 … t+N−1 keep it high).
  - HI/LO hold the new values and `busy` = 0 after edge t+N.
  - N = MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO accepted at edge t: the new value is visible on `mdu_out` (via MFHI/MFLO) in cycle t+1.
- `req` and `start` in the same cycle: no accept, no HI/LO write, `busy` stays 0.
- Back-to-back: a new op may be accepted in the first cycle with `busy` = 0, and it sees the just-committed HI/LO.

## Configuration
- `MDU_MADD_EN` defined: ops 9/10 are implemented as above.
- `MDU_MADD_EN` undefined: ops 9/10 are no-ops, with no busy and no HI/LO change. The accumulate adder is not synthesised.

## Structure
- Package `mdu_pkg` holds:
  - the op encoding localparams;
  - FSM state encoding (IDLE/BUSY);
  - default latency constants;
  - the divide-by-zero result constant.
- Sub-module `mdu_arith`: combinational 64-bit product/quotient/remainder/accumulate from the latched operands and op.
- `e_mdu` keeps the FSM, counter, operand latches and HI/LO.

## Test plan
- MULT A=32'hFFFF_FFFE (−2), B=3: `busy` is high 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- DIVU A=7, B=0: `busy` is high 10 cycles, then LO=32'hFFFF_FFFF, HI=7. DIV A=−7, B=2 gives LO=−3, HI=−1.
- MTLO A=32'h1234_5678, then MFLO next cycle: `mdu_out`=32'h1234_5678. MTHI together with `req`=1: HI is unchanged.
- MULT accepted, then `req`=1 at busy cycle 2: the op still completes, with HI/LO written after 5 cycles. `start`+`req` on the same cycle: `busy` never rises.
- `reset`=0 at busy cycle 3 of a DIV: `busy`, HI and LO are 0 immediately, with no later write.
- With `MDU_MADD_EN`, HI:LO=0:5 and MADDU A=2, B=3: LO=11 after 5 cycles. Without the macro, the same stimulus leaves LO=5 and `busy` stays 0.
